// File: rtl/sync_fifo_fwft_pkg.sv
// Shared definitions for the single-clock FIFO family: read-mode
// constants and the address-width helper used to size pointers.
package sync_fifo_fwft_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  // Address bits needed to index a RAM of the given depth (never zero).
  function automatic int fifo_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft_sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// output. Contents and read register are never reset so the array maps
// onto block RAM.
module sdp_ram
  import sync_fifo_fwft_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [fifo_addr_w(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          re,
  input  logic [fifo_addr_w(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]              rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_q;

  // Write port: store the incoming word when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Read port: capture the addressed word when enabled, hold otherwise.
  always_ff @(posedge clk) begin
    if (re) begin
      r_q <= r_mem[raddr];
    end
  end

  assign rdata = r_q;

endmodule

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with selectable standard or first-word-fall-through
// read mode, threshold flags, occupancy output, synchronous flush and
// sticky overflow/underflow flags. The RAM read register doubles as the
// output register in both modes; rd_data is masked to zero until the
// first word has been loaded after reset or flush.
module sync_fifo_fwft
  import sync_fifo_fwft_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 256,
  parameter int FWFT      = FIFO_STD,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = fifo_addr_w(DEPTH);
  localparam int LW = AW + 1;
  localparam bit IS_FWFT = (FWFT == FIFO_FWFT);
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_TH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_TH);

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             r_valid;
  logic             r_q_live;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_ram_we;
  logic             w_ram_re;
  logic             w_valid_nxt;
  logic [LW-1:0]    w_level_nxt;
  logic [LW-1:0]    w_ram_cnt;
  logic [WIDTH-1:0] w_ram_q;

  assign w_full  = (r_level == DEPTH_L);
  assign w_empty = IS_FWFT ? ~r_valid : (r_level == {LW{1'b0}});

  // Acceptance, RAM port enables, next level and next valid state.
  always_comb begin
    w_wr_ok     = wr_en & ~w_full;
    w_rd_ok     = rd_en & ~w_empty;
    // Words still in the RAM, excluding the one presented at the output.
    w_ram_cnt   = r_level - {{(LW-1){1'b0}}, r_valid};
    w_ram_we    = w_wr_ok & ~clr;
    w_ram_re    = 1'b0;
    w_valid_nxt = r_valid;
    w_level_nxt = r_level;

    if (IS_FWFT) begin
      // Prefetch whenever the output slot is free or being popped.
      w_ram_re = (w_ram_cnt != {LW{1'b0}}) & (~r_valid | w_rd_ok) & ~clr;
      if (w_ram_re) begin
        w_valid_nxt = 1'b1;
      end else if (w_rd_ok) begin
        w_valid_nxt = 1'b0;
      end else begin
        w_valid_nxt = r_valid;
      end
    end else begin
      w_ram_re    = w_rd_ok & ~clr;
      w_valid_nxt = w_rd_ok;
    end

    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_level_nxt = r_level + {{(LW-1){1'b0}}, 1'b1};
      2'b01:   w_level_nxt = r_level - {{(LW-1){1'b0}}, 1'b1};
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointer, level, valid and sticky-flag registers with async reset and flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_level     <= {LW{1'b0}};
      r_valid     <= 1'b0;
      r_q_live    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (clr) begin
      r_wr_ptr    <= {AW{1'b0}};
      r_rd_ptr    <= {AW{1'b0}};
      r_level     <= {LW{1'b0}};
      r_valid     <= 1'b0;
      r_q_live    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      if (w_ram_re) begin
        r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
      end
      r_level     <= w_level_nxt;
      r_valid     <= w_valid_nxt;
      r_q_live    <= r_q_live | w_ram_re;
      r_overflow  <= r_overflow | (wr_en & w_full);
      r_underflow <= r_underflow | (rd_en & w_empty);
    end
  end

  sdp_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (w_ram_we),
    .waddr (r_wr_ptr),
    .wdata (wr_data),
    .re    (w_ram_re),
    .raddr (r_rd_ptr),
    .rdata (w_ram_q)
  );

  assign rd_data      = r_q_live ? w_ram_q : {WIDTH{1'b0}};
  assign rd_valid     = r_valid;
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_full  = (r_level >= AFULL_L);
  assign almost_empty = (r_level <= AEMPTY_L);
  assign level        = r_level;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed bench for sync_fifo_fwft: one standard-mode and one FWFT-mode
// instance (DEPTH=8, almost_full at 4, almost_empty at 2), each driven
// through fill/drain, full/empty collisions, wrap, flush and async reset.
module tb_sync_fifo_fwft;

  logic clk;
  logic rst_n;

  logic       s_clr, s_wr, s_rd;
  logic [7:0] s_wd, s_rdata;
  logic       s_rvalid, s_empty, s_full, s_af, s_ae, s_ovf, s_udf;
  logic [3:0] s_level;

  logic       f_clr, f_wr, f_rd;
  logic [7:0] f_wd, f_rdata;
  logic       f_rvalid, f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
  logic [3:0] f_level;

  int n_checks;
  int n_fail;

  sync_fifo_fwft #(
    .WIDTH(8), .DEPTH(8), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(2)
  ) u_std (
    .clk(clk), .rst_n(rst_n), .clr(s_clr), .wr_en(s_wr), .wr_data(s_wd),
    .rd_en(s_rd), .rd_data(s_rdata), .rd_valid(s_rvalid), .empty(s_empty),
    .full(s_full), .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow(s_ovf), .underflow(s_udf)
  );

  sync_fifo_fwft #(
    .WIDTH(8), .DEPTH(8), .FWFT(1), .AFULL_TH(4), .AEMPTY_TH(2)
  ) u_fwft (
    .clk(clk), .rst_n(rst_n), .clr(f_clr), .wr_en(f_wr), .wr_data(f_wd),
    .rd_en(f_rd), .rd_data(f_rdata), .rd_valid(f_rvalid), .empty(f_empty),
    .full(f_full), .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow(f_ovf), .underflow(f_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_reset(input string p, input logic [7:0] rdata, input logic rvalid,
                              input logic emp, input logic ful, input logic af, input logic ae,
                              input logic [3:0] lvl, input logic ovf, input logic udf);
    check_eq({p, "_rd_data"},      32'(rdata),  32'h0);
    check_eq({p, "_rd_valid"},     32'(rvalid), 32'h0);
    check_eq({p, "_empty"},        32'(emp),    32'h1);
    check_eq({p, "_full"},         32'(ful),    32'h0);
    check_eq({p, "_almost_full"},  32'(af),     32'h0);
    check_eq({p, "_almost_empty"}, 32'(ae),     32'h1);
    check_eq({p, "_level"},        32'(lvl),    32'h0);
    check_eq({p, "_overflow"},     32'(ovf),    32'h0);
    check_eq({p, "_underflow"},    32'(udf),    32'h0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    s_clr = 1'b0; s_wr = 1'b0; s_rd = 1'b0; s_wd = 8'h00;
    f_clr = 1'b0; f_wr = 1'b0; f_rd = 1'b0; f_wd = 8'h00;
    step();
    step();
    expect_reset("rst_std", s_rdata, s_rvalid, s_empty, s_full, s_af, s_ae, s_level, s_ovf, s_udf);
    expect_reset("rst_fwft", f_rdata, f_rvalid, f_empty, f_full, f_af, f_ae, f_level, f_ovf, f_udf);
    rst_n = 1'b1;
    step();

    // Standard mode: fill 0x01..0x08, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      s_wr = 1'b1; s_wd = 8'(i);
      step();
      check_eq("fill_level", 32'(s_level), 32'(i));
      check_eq("fill_afull", 32'(s_af), (i >= 4) ? 32'h1 : 32'h0);
      check_eq("fill_full",  32'(s_full), (i == 8) ? 32'h1 : 32'h0);
    end
    s_wr = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      s_rd = 1'b1;
      step();
      check_eq("drain_data",  32'(s_rdata), 32'(i));
      check_eq("drain_valid", 32'(s_rvalid), 32'h1);
      check_eq("drain_level", 32'(s_level), 32'(8 - i));
    end
    s_rd = 1'b0;
    step();
    check_eq("drain_valid_drop", 32'(s_rvalid), 32'h0);
    check_eq("drain_data_hold",  32'(s_rdata), 32'h08);
    check_eq("drain_empty",      32'(s_empty), 32'h1);

    // Standard mode: write+read while full drops the write, reads the head.
    for (int i = 0; i < 8; i++) begin
      s_wr = 1'b1; s_wd = 8'(8'h10 + i);
      step();
    end
    check_eq("full2_full", 32'(s_full), 32'h1);
    s_wr = 1'b1; s_wd = 8'hEE; s_rd = 1'b1;
    step();
    check_eq("coll_full_data",  32'(s_rdata), 32'h10);
    check_eq("coll_full_level", 32'(s_level), 32'h7);
    check_eq("coll_full_ovf",   32'(s_ovf), 32'h1);
    check_eq("coll_full_full",  32'(s_full), 32'h0);
    s_wr = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      check_eq("coll_rest_data", 32'(s_rdata), 32'(8'h10 + i));
      check_eq("coll_ovf_sticky", 32'(s_ovf), 32'h1);
    end
    s_rd = 1'b0;
    step();
    check_eq("coll_end_empty", 32'(s_empty), 32'h1);
    check_eq("coll_end_level", 32'(s_level), 32'h0);

    // Standard mode: read while empty, then write+read while empty.
    s_rd = 1'b1;
    step();
    check_eq("udf_flag",  32'(s_udf), 32'h1);
    check_eq("udf_level", 32'(s_level), 32'h0);
    check_eq("udf_valid", 32'(s_rvalid), 32'h0);
    s_wr = 1'b1; s_wd = 8'h5C;
    step();
    check_eq("coll_empty_level", 32'(s_level), 32'h1);
    check_eq("coll_empty_valid", 32'(s_rvalid), 32'h0);
    s_wr = 1'b0;
    step();
    check_eq("coll_empty_data",  32'(s_rdata), 32'h5C);
    check_eq("coll_empty_rv",    32'(s_rvalid), 32'h1);
    check_eq("coll_empty_lvl0",  32'(s_level), 32'h0);
    s_rd = 1'b0;

    // Flush at level 5 with a concurrent write.
    for (int i = 0; i < 5; i++) begin
      s_wr = 1'b1; s_wd = 8'(8'h21 + i);
      step();
    end
    check_eq("pre_clr_level", 32'(s_level), 32'h5);
    s_clr = 1'b1; s_wd = 8'h99;
    step();
    s_clr = 1'b0; s_wr = 1'b0;
    expect_reset("clr_std", s_rdata, s_rvalid, s_empty, s_full, s_af, s_ae, s_level, s_ovf, s_udf);
    s_wr = 1'b1; s_wd = 8'h33;
    step();
    s_wr = 1'b0; s_rd = 1'b1;
    step();
    s_rd = 1'b0;
    check_eq("post_clr_data", 32'(s_rdata), 32'h33);

    // FWFT: single word falls through one edge after the write.
    f_wr = 1'b1; f_wd = 8'hA5;
    step();
    f_wr = 1'b0;
    check_eq("fw_lvl_k",   32'(f_level), 32'h1);
    check_eq("fw_empty_k", 32'(f_empty), 32'h1);
    check_eq("fw_rv_k",    32'(f_rvalid), 32'h0);
    step();
    check_eq("fw_rv_k1",   32'(f_rvalid), 32'h1);
    check_eq("fw_data_k1", 32'(f_rdata), 32'hA5);
    check_eq("fw_empty_k1", 32'(f_empty), 32'h0);
    f_rd = 1'b1;
    step();
    f_rd = 1'b0;
    check_eq("fw_pop_empty", 32'(f_empty), 32'h1);
    check_eq("fw_pop_level", 32'(f_level), 32'h0);

    // FWFT: fill to full, then back-to-back pops at one word per cycle.
    for (int i = 0; i < 8; i++) begin
      f_wr = 1'b1; f_wd = 8'(8'h61 + i);
      step();
      check_eq("fw_fill_level", 32'(f_level), 32'(i + 1));
    end
    f_wr = 1'b0;
    check_eq("fw_full", 32'(f_full), 32'h1);
    check_eq("fw_afull", 32'(f_af), 32'h1);
    for (int i = 0; i < 8; i++) begin
      check_eq("fw_stream_data",  32'(f_rdata), 32'(8'h61 + i));
      check_eq("fw_stream_valid", 32'(f_rvalid), 32'h1);
      f_rd = 1'b1;
      step();
    end
    f_rd = 1'b0;
    check_eq("fw_drain_empty", 32'(f_empty), 32'h1);
    check_eq("fw_drain_level", 32'(f_level), 32'h0);

    // FWFT: write+read while full.
    for (int i = 0; i < 8; i++) begin
      f_wr = 1'b1; f_wd = 8'(8'h70 + i);
      step();
    end
    check_eq("fw_full2", 32'(f_full), 32'h1);
    check_eq("fw_head2", 32'(f_rdata), 32'h70);
    f_wr = 1'b1; f_wd = 8'hEE; f_rd = 1'b1;
    step();
    f_wr = 1'b0; f_rd = 1'b0;
    check_eq("fw_coll_level", 32'(f_level), 32'h7);
    check_eq("fw_coll_ovf",   32'(f_ovf), 32'h1);
    check_eq("fw_coll_next",  32'(f_rdata), 32'h71);

    // Standard mode: stream 20 words at constant level 3 across the wrap.
    for (int i = 0; i < 3; i++) begin
      s_wr = 1'b1; s_wd = 8'(8'h40 + i);
      step();
    end
    for (int i = 0; i < 20; i++) begin
      s_wr = 1'b1; s_rd = 1'b1; s_wd = 8'(8'h43 + i);
      step();
      check_eq("wrap_data",  32'(s_rdata), 32'(8'h40 + i));
      check_eq("wrap_level", 32'(s_level), 32'h3);
      check_eq("wrap_flags", 32'({s_full, s_af, s_ae, s_ovf, s_udf}), 32'h0);
    end
    s_wr = 1'b0; s_rd = 1'b0;

    // Async reset away from any clock edge.
    rst_n = 1'b0;
    #2;
    expect_reset("arst_std", s_rdata, s_rvalid, s_empty, s_full, s_af, s_ae, s_level, s_ovf, s_udf);
    expect_reset("arst_fwft", f_rdata, f_rvalid, f_empty, f_full, f_af, f_ae, f_level, f_ovf, f_udf);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
